iq_sample_player: RTL
=====================

# iq_sample_player

RAM-backed complex sample source that drives the input side of the NCO mixer chain. Before playback, software or a bench loads signed 8-bit I/Q pairs into an internal buffer. Playback emits `real_o`/`imag_o`/`valid_o` at a programmable sample interval, either once or looped. These outputs connect directly to the mixer's `real_i`/`imag_i`/`valid_i`.

## Interface
- `ADDR_W`, 8: buffer address width; depth is 2^ADDR_W samples.
- `INT_W`, 16: width of the interval register.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en_i`  in  1  write strobe for the load port.
- `wr_addr_i`  in  ADDR_W  load address.
- `wr_real_i`, `wr_imag_i`  in  8 each  signed sample to store.
- `start_i`  in  1  start playback; a single-cycle pulse is sufficient.
- `stop_i`  in  1  abort playback.
- `last_addr_i`  in  ADDR_W  address of the final sample; playback covers addresses 0..last_addr_i.
- `interval_i`  in  INT_W  idle cycles inserted between output samples; 0 means one sample every cycle.
- `loop_i`  in  1  1 = wrap from last_addr back to 0 indefinitely.
- `real_o`, `imag_o`  out  8 each  signed output sample.
- `valid_o`  out  1  one-cycle qualifier for each sample.
- `busy_o`  out  1  high while state != IDLE.
- `done_o`  out  1  one-cycle pulse marking completion of a non-looped run.

## Operation
- The buffer is a 2^ADDR_W x 16 memory with a synchronous write port and a synchronous read port. Its contents are not reset.
- Writes are accepted only in IDLE. Writes in PLAY or DRAIN are ignored.
- FSM states:
  - IDLE: waiting for `start_i`.
  - PLAY: issuing reads.
  - DRAIN: the final read is in flight.
- Transitions:
  - IDLE -> PLAY on `start_i`=1 with `stop_i`=0. On this edge, `last_addr_i`, `interval_i` and `loop_i` are latched, the read address is set to 0 and the gap counter is set to 0. Later changes to these inputs have no effect until the next start.
  - In PLAY, when the gap counter is 0, the current address is read, the counter reloads to the latched interval, and the read-valid flag is set. Otherwise the counter decrements.
  - When the address read is the latched last_addr:
    - loop=1: the next address is 0 and the FSM stays in PLAY.
    - loop=0: the FSM moves to DRAIN.
  - DRAIN -> IDLE on the next edge. `done_o`=1 and `valid_o`=1 on that edge.
  - `stop_i`=1 in PLAY or DRAIN -> IDLE on that edge. The read-valid flag is cleared, no further `valid_o` is produced, and `done_o` is not asserted.
- `start_i` is ignored in PLAY and DRAIN.
- `start_i` and `stop_i` both high in IDLE: stop wins and the FSM stays in IDLE.
- When a read is valid, the output register loads `real_o`/`imag_o` from the read data. At all other times `real_o`/`imag_o` hold their last value.
- Reset values: `real_o`=0, `imag_o`=0, `valid_o`=0, `busy_o`=0, `done_o`=0, FSM = IDLE, counters = 0.

## Timing
- Edge k samples `start_i`. The first `valid_o` is high in the cycle following edge k+2, giving a start-to-first-sample latency of 2 clocks.
- Sample n (counting every emitted sample, across loop wraps) appears at edge k+2+n·(interval+1). Spacing stays uniform across the wrap.
- Pipeline from read-issue to the `valid_o` edge: 1 clock (read-data register, then output register).
- Non-looped run: exactly last_addr+1 `valid_o` pulses. `done_o` coincides with the final pulse. `busy_o` falls on that same edge.
- `stop_i` sampled at edge s: `valid_o`=0 from edge s onward, including any sample already in flight.
- Asserting `rst` forces all outputs to their reset values immediately, independent of `clk`. Playback resumes only on a new start after reset is released.

## Test plan
- **Single run, back-to-back:**
  - Stimulus: load addr0=(10,-10), 1=(20,-20), 2=(30,-30), 3=(-128,127); last_addr=3, interval=0, loop=0; start.
  - Required response: `valid_o` high for 4 consecutive cycles beginning 2 clocks after start, with values in address order. `done_o` is high with the 4th pulse. `busy_o` is 0 afterwards.
- **Spaced run:**
  - Stimulus: same buffer, interval=3.
  - Required response: exactly 4 pulses, 4 clocks apart, with `done_o` on the 4th pulse.
- **Looped run with stop:**
  - Stimulus: last_addr=2, interval=1, loop=1; after 7 pulses, assert `stop_i`.
  - Required response: pulse sequence 10,20,30,10,20,30,10 at 2-clock spacing. `valid_o` is 0 from the stop edge onward, `done_o` never asserts, and `busy_o`=0.
- **Single sample:**
  - Stimulus: last_addr=0.
  - Required response: one pulse (10,-10), with `done_o` on the same cycle.
- **Reset and write lockout:**
  - Stimulus: during a looped run, write addr1=(99,99), then assert `rst` mid-play.
  - Required response: all outputs go to 0 asynchronously. A replay after reset still outputs (20,-20) at addr1, because the write during play was ignored.
- **Control corner cases:**
  - Stimulus: `start_i` and `stop_i` together in IDLE.
  - Required response: no `busy_o`, no `valid_o`.
  - Stimulus: re-pulse `start_i` during PLAY.
  - Required response: sequence and timing unchanged.

Source files
------------

// File: rtl/iq_sample_player_if.sv
// -----------------------------------------------------------------------------
// iq_sample_player_if
// Complex sample stream leaving the sample player and entering the mixer.
//   real_o  : signed 8-bit in-phase sample
//   imag_o  : signed 8-bit quadrature sample
//   valid_o : one-cycle qualifier for each sample
// Modports:
//   master : the sample player (drives the stream)
//   slave  : the consumer (mixer real_i/imag_i/valid_i)
// -----------------------------------------------------------------------------
interface iq_sample_player_if;
    logic signed [7:0] real_o;
    logic signed [7:0] imag_o;
    logic              valid_o;

    modport master (
        output real_o,
        output imag_o,
        output valid_o
    );

    modport slave (
        input real_o,
        input imag_o,
        input valid_o
    );
endinterface

// File: rtl/iq_sample_player.sv
// -----------------------------------------------------------------------------
// iq_sample_player
// RAM-backed complex sample source. Signed 8-bit I/Q pairs are loaded into a
// 2^ADDR_W deep buffer while idle, then played out from address 0 up to a
// latched last address, one sample every (interval+1) clocks, once or looped.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-low reset
//   wr_en_i      load strobe (honoured only while idle)
//   wr_addr_i    load address
//   wr_real_i    signed I sample to store
//   wr_imag_i    signed Q sample to store
//   start_i      start playback (single-cycle pulse is enough)
//   stop_i       abort playback; also blocks a simultaneous start
//   last_addr_i  address of the final sample, latched on start
//   interval_i   idle cycles between samples, latched on start
//   loop_i       1 = wrap to address 0 after last_addr, latched on start
//   smp          sample stream out (real_o / imag_o / valid_o)
//   busy_o       high whenever the FSM is not idle
//   done_o       one-cycle pulse with the final sample of a non-looped run
//
// Pipeline: read issued at edge r -> read-data register; edge r+1 -> output
// register, so valid_o is high in the cycle after edge r+1.
// -----------------------------------------------------------------------------
module iq_sample_player #(
    parameter int ADDR_W = 8,
    parameter int INT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic signed [7:0]        wr_real_i,
    input  logic signed [7:0]        wr_imag_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [ADDR_W-1:0]        last_addr_i,
    input  logic [INT_W-1:0]         interval_i,
    input  logic                     loop_i,
    iq_sample_player_if.master       smp,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [INT_W-1:0]  GAP_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Run parameters captured on start, plus the playback counters.
    logic [ADDR_W-1:0] last_q, last_d;
    logic [INT_W-1:0]  intv_q, intv_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INT_W-1:0]  gap_q,  gap_d;

    // Read pipeline and output stage.
    logic              rd_valid_q, rd_valid_d;
    logic [15:0]       rd_data_q;
    logic signed [7:0] real_q, real_d;
    logic signed [7:0] imag_q, imag_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    // Decoded controls.
    logic start_ok;
    logic abort;
    logic rd_en;
    logic wr_ok;
    logic at_last;

    // Sample buffer: {real, imag} per word, contents deliberately not reset.
    logic [15:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (rd_en && at_last && !loop_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leaves on the next edge whether or not stop is asserted;
                // stop only suppresses the final sample and done.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        // Stop has priority over start when both arrive while idle.
        start_ok = (state_q == S_IDLE) && start_i && !stop_i;
        abort    = (state_q != S_IDLE) && stop_i;
        // No point reading on the edge that aborts the run.
        rd_en    = (state_q == S_PLAY) && (gap_q == '0) && !stop_i;
        wr_ok    = (state_q == S_IDLE) && wr_en_i;
        at_last  = (addr_q == last_q);
    end

    // ------------------------------------------------------------------
    // Playback counters and latched run parameters
    // ------------------------------------------------------------------
    always_comb begin
        last_d     = last_q;
        intv_d     = intv_q;
        loop_d     = loop_q;
        addr_d     = addr_q;
        gap_d      = gap_q;
        rd_valid_d = rd_en;

        if (start_ok) begin
            last_d = last_addr_i;
            intv_d = interval_i;
            loop_d = loop_i;
            addr_d = '0;
            gap_d  = '0;
        end else if (abort) begin
            addr_d = '0;
            gap_d  = '0;
        end else if (state_q == S_PLAY) begin
            if (gap_q == '0) begin
                // Reload rather than count from interval-1 so spacing is
                // exactly interval+1 clocks, including across a loop wrap.
                gap_d  = intv_q;
                addr_d = at_last ? '0 : (addr_q + ADDR_ONE);
            end else begin
                gap_d = gap_q - GAP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= '0;
            intv_q     <= '0;
            loop_q     <= 1'b0;
            addr_q     <= '0;
            gap_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            intv_q     <= intv_d;
            loop_q     <= loop_d;
            addr_q     <= addr_d;
            gap_q      <= gap_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Buffer: synchronous write port, registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr_i] <= {wr_real_i, wr_imag_i};
        end
        if (rd_en) begin
            rd_data_q <= mem[addr_q];
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_comb begin
        // A stop kills the sample already in the read register as well.
        valid_d = rd_valid_q && !abort;
        // Only DRAIN can complete a run; the final sample rides with done.
        done_d  = (state_q == S_DRAIN) && !stop_i;
        real_d  = real_q;
        imag_d  = imag_q;
        if (valid_d) begin
            real_d = rd_data_q[15:8];
            imag_d = rd_data_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            real_q  <= '0;
            imag_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            real_q  <= real_d;
            imag_q  <= imag_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign smp.real_o  = real_q;
    assign smp.imag_o  = imag_q;
    assign smp.valid_o = valid_q;
    assign done_o      = done_q;

endmodule
